// File: rtl/ddr_cmd_issue.sv
// DDR command issuer: one registered command per accept, NOP gaps, self-refresh/power-down CKE.
// Optional open-bank tracking with protocol checks when DDR_BANK_TRACK_EN is defined.
module ddr_cmd_issue #(
  parameter int unsigned ROW_W   = 13,
  parameter int unsigned COL_W   = 9,
  parameter int unsigned BANK_W  = 2,
  parameter int unsigned RANK_N  = 2,
  parameter int unsigned CMD_GAP = 1,
  parameter int unsigned XSR_CYC = 200,
  localparam int unsigned RANK_W = (RANK_N > 1) ? $clog2(RANK_N) : 1,
  localparam int unsigned ADDR_W = ROW_W + RANK_W + BANK_W + COL_W,
  localparam int unsigned BANKS  = RANK_N * (2 ** BANK_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ROW_W-1:0]  cmd_mode,
  input  logic              cke_en,
  output logic [RANK_N-1:0] ddr_cke,
  output logic [RANK_N-1:0] ddr_cs_n,
  output logic              ddr_ras_n,
  output logic              ddr_cas_n,
  output logic              ddr_we_n,
  output logic [ROW_W-1:0]  ddr_addr,
  output logic [BANK_W-1:0] ddr_ba,
  output logic              protocol_err,
  output logic [BANKS-1:0]  bank_open
);

  localparam logic [3:0] OpNop    = 4'd0;
  localparam logic [3:0] OpAct    = 4'd1;
  localparam logic [3:0] OpRd     = 4'd2;
  localparam logic [3:0] OpWr     = 4'd3;
  localparam logic [3:0] OpRda    = 4'd4;
  localparam logic [3:0] OpWra    = 4'd5;
  localparam logic [3:0] OpPre    = 4'd6;
  localparam logic [3:0] OpPrea   = 4'd7;
  localparam logic [3:0] OpRef    = 4'd8;
  localparam logic [3:0] OpLmr    = 4'd9;
  localparam logic [3:0] OpEmr    = 4'd10;
  localparam logic [3:0] OpSrefEn = 4'd11;
  localparam logic [3:0] OpSrefEx = 4'd12;
  localparam logic [3:0] OpPdnEn  = 4'd13;
  localparam logic [3:0] OpPdnEx  = 4'd14;
  localparam logic [3:0] OpRsvd   = 4'd15;

  localparam int unsigned CNT_W = $clog2(XSR_CYC + 1);

  typedef enum logic [2:0] {StIdle, StIssue, StGap, StSref, StPdn} state_e;

  state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_op;
  logic               r_lp, w_lp_nxt;
  logic [RANK_N-1:0]  r_cke, r_cs_n, w_cs_n, w_rank_sel;
  logic [2:0]         r_rcw, w_rcw;
  logic [ROW_W-1:0]   r_addr, w_addr, w_col_addr;
  logic [BANK_W-1:0]  r_ba, w_ba;
  logic               r_perr, w_perr_set, w_trk_err;
  logic               w_accept, w_rank_op, w_rank_bad;
  logic [COL_W-1:0]   w_col;
  logic [BANK_W-1:0]  w_bank;
  logic [RANK_W-1:0]  w_rank;
  logic [ROW_W-1:0]   w_row;

  assign w_col      = cmd_addr[COL_W-1:0];
  assign w_bank     = cmd_addr[COL_W +: BANK_W];
  assign w_rank     = cmd_addr[COL_W+BANK_W +: RANK_W];
  assign w_row      = cmd_addr[COL_W+BANK_W+RANK_W +: ROW_W];
  assign w_rank_op  = (cmd_op >= OpAct) && (cmd_op <= OpPre);
  assign w_rank_bad = w_rank_op && (32'(w_rank) >= RANK_N);
  assign w_rank_sel = ~(RANK_N'(1) << w_rank);
  assign w_accept   = cmd_valid && cmd_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle, StSref, StPdn: if (w_accept) w_state_nxt = StIssue;
      StIssue: begin
        if (r_op == OpSrefEn)     w_state_nxt = StSref;
        else if (r_op == OpPdnEn) w_state_nxt = StPdn;
        else                      w_state_nxt = StGap;
      end
      StGap:   if (r_cnt <= CNT_W'(1)) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Outputs: in low-power states only the matching exit opcode is accepted
  always_comb begin
    cmd_ready = 1'b0;
    if (rst_n) begin
      unique case (r_state)
        StIdle:  cmd_ready = 1'b1;
        StSref:  cmd_ready = (cmd_op == OpSrefEx);
        StPdn:   cmd_ready = (cmd_op == OpPdnEx);
        default: cmd_ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_op  <= OpNop;
    end else begin
      if (w_accept) r_op <= cmd_op;
      if (r_state == StIssue && w_state_nxt == StGap) begin
        r_cnt <= (r_op == OpSrefEx) ? CNT_W'(XSR_CYC) : CNT_W'(CMD_GAP);
      end else if (r_state == StGap && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    w_col_addr               = '0;
    w_col_addr[COL_W-1:0]    = w_col;
    w_col_addr[10]           = (cmd_op == OpRda) || (cmd_op == OpWra);
  end

  // Pin values for an accepted command; address and bank hold unless the command drives them
  always_comb begin
    w_cs_n = '1;
    w_rcw  = 3'b111;
    w_addr = r_addr;
    w_ba   = r_ba;
    if (!w_rank_bad) begin
      case (cmd_op)
        OpAct: begin
          w_cs_n = w_rank_sel; w_rcw = 3'b011; w_addr = w_row; w_ba = w_bank;
        end
        OpRd, OpRda: begin
          w_cs_n = w_rank_sel; w_rcw = 3'b101; w_addr = w_col_addr; w_ba = w_bank;
        end
        OpWr, OpWra: begin
          w_cs_n = w_rank_sel; w_rcw = 3'b100; w_addr = w_col_addr; w_ba = w_bank;
        end
        OpPre: begin
          w_cs_n = w_rank_sel; w_rcw = 3'b010; w_addr = '0; w_ba = w_bank;
        end
        OpPrea: begin
          w_cs_n = '0; w_rcw = 3'b010; w_addr = '0; w_addr[10] = 1'b1;
        end
        OpRef, OpSrefEn: begin
          w_cs_n = '0; w_rcw = 3'b001;
        end
        OpLmr: begin
          w_cs_n = '0; w_rcw = 3'b000; w_addr = cmd_mode; w_ba = '0;
        end
        OpEmr: begin
          w_cs_n = '0; w_rcw = 3'b000; w_addr = cmd_mode; w_ba = BANK_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_lp_nxt = r_lp;
    if (w_accept) begin
      if (cmd_op == OpSrefEn || cmd_op == OpPdnEn)      w_lp_nxt = 1'b1;
      else if (cmd_op == OpSrefEx || cmd_op == OpPdnEx) w_lp_nxt = 1'b0;
    end
  end

  assign w_perr_set = w_accept && ((cmd_op == OpRsvd) || w_rank_bad || w_trk_err);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lp   <= 1'b0;
      r_cke  <= '0;
      r_cs_n <= '1;
      r_rcw  <= 3'b111;
      r_addr <= '0;
      r_ba   <= '0;
      r_perr <= 1'b0;
    end else begin
      r_lp  <= w_lp_nxt;
      r_cke <= w_lp_nxt ? '0 : {RANK_N{cke_en}};
      if (w_accept) begin
        r_cs_n <= w_cs_n;
        r_rcw  <= w_rcw;
        r_addr <= w_addr;
        r_ba   <= w_ba;
      end else begin
        r_cs_n <= '1;
        r_rcw  <= 3'b111;
      end
      if (w_perr_set) r_perr <= 1'b1;
    end
  end

`ifdef DDR_BANK_TRACK_EN
  logic [BANKS-1:0]         r_bank_open, w_bank_open_nxt;
  logic [RANK_W+BANK_W-1:0] w_bidx;
  logic                     w_hit;

  assign w_bidx = {w_rank, w_bank};
  assign w_hit  = r_bank_open[w_bidx];

  // Misordered commands flag an error but are still issued
  always_comb begin
    w_bank_open_nxt = r_bank_open;
    w_trk_err       = 1'b0;
    if (w_accept && !w_rank_bad) begin
      case (cmd_op)
        OpAct: begin
          w_trk_err = w_hit; w_bank_open_nxt[w_bidx] = 1'b1;
        end
        OpRd, OpWr: w_trk_err = !w_hit;
        OpRda, OpWra: begin
          w_trk_err = !w_hit; w_bank_open_nxt[w_bidx] = 1'b0;
        end
        OpPre:  w_bank_open_nxt[w_bidx] = 1'b0;
        OpPrea: w_bank_open_nxt = '0;
        OpRef, OpLmr, OpEmr, OpSrefEn: w_trk_err = |r_bank_open;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_bank_open <= '0;
    else        r_bank_open <= w_bank_open_nxt;
  end

  assign bank_open = r_bank_open;
`else
  assign w_trk_err = 1'b0;
  assign bank_open = '0;
`endif

  assign ddr_cke                           = r_cke;
  assign ddr_cs_n                          = r_cs_n;
  assign {ddr_ras_n, ddr_cas_n, ddr_we_n}  = r_rcw;
  assign ddr_addr                          = r_addr;
  assign ddr_ba                            = r_ba;
  assign protocol_err                      = r_perr;

endmodule

// File: doc/ddr_cmd_issue.md
DDR_CMD_ISSUE -- requirements
Module: ddr_cmd_issue

Interface
REQ-001 The block SHALL provide parameter ROW_W, default 13, meaning the row/address-bus width (ROW_W >= 11).
REQ-002 The block SHALL provide parameter COL_W, default 9, meaning the column width (COL_W <= 10).
REQ-003 The block SHALL provide parameter BANK_W, default 2, meaning the bank-address width.
REQ-004 The block SHALL provide parameter RANK_N, default 2, meaning the chip-select count (1..4); RANK_W = max(1, clog2(RANK_N)).
REQ-005 The block SHALL provide parameter CMD_GAP, default 1, meaning the NOP cycles enforced after each command (>= 1).
REQ-006 The block SHALL provide parameter XSR_CYC, default 200, meaning the NOP cycles enforced after SREF_EX (>= CMD_GAP).
REQ-007 The block SHALL have ports: clk in 1, clock; rst_n in 1, reset, synchronous, active-low.
REQ-008 The block SHALL have ports: cmd_valid in 1, request; cmd_ready out 1, accept; cmd_op in 4, opcode; cmd_addr in ROW_W+RANK_W+BANK_W+COL_W, {row, rank, bank, col}; cmd_mode in ROW_W, LMR/EMR value; cke_en in 1, CKE request from init sequencer.
REQ-009 The block SHALL have ports: ddr_cke out RANK_N; ddr_cs_n out RANK_N; ddr_ras_n, ddr_cas_n, ddr_we_n out 1 each; ddr_addr out ROW_W; ddr_ba out BANK_W; protocol_err out 1, sticky; bank_open out RANK_N*2^BANK_W, open-bank bitmap.

Function
REQ-010 Opcodes SHALL be: 0 NOP, 1 ACT, 2 RD, 3 WR, 4 RDA, 5 WRA, 6 PRE, 7 PREA, 8 REF, 9 LMR, 10 EMR, 11 SREF_EN, 12 SREF_EX, 13 PDN_EN, 14 PDN_EX; 15 is reserved, treated as NOP, and sets protocol_err.
REQ-011 A command SHALL be accepted on a rising edge with cmd_valid && cmd_ready; the pins SHALL carry it on the next cycle for exactly one cycle.
REQ-012 Every non-issue cycle SHALL drive a deselect: ddr_cs_n all 1 and ras/cas/we 1; ddr_addr and ddr_ba hold their values.
REQ-013 The FSM SHALL use states IDLE, ISSUE, GAP, SREF, and PDN.
REQ-014 IDLE->ISSUE on accept; ISSUE->GAP with counter=CMD_GAP (XSR_CYC after SREF_EX); GAP->IDLE at count 0.
REQ-015 ISSUE after SREF_EN or PDN_EN SHALL go to SREF or PDN respectively.
REQ-016 cmd_ready SHALL be 1 only in IDLE, or in SREF/PDN when cmd_op is the matching exit opcode.
REQ-017 Accepting NOP SHALL still consume ISSUE+GAP with a deselect on the pins.
REQ-018 Rank-targeted ops (ACT, RD, WR, RDA, WRA, PRE) SHALL drive low only ddr_cs_n[rank], with ddr_ba = bank; PREA, REF, LMR, EMR, and SREF_EN SHALL drive all ranks low.
REQ-019 Encodings SHALL be (RAS/CAS/WE): ACT 011 with ddr_addr = row; RD/RDA 101; WR/WRA 100; PRE/PREA 010; REF 001; SREF_EN 001; LMR/EMR 000.
REQ-020 For RD/WR/RDA/WRA, ddr_addr[COL_W-1:0] SHALL be col, with other bits 0 except A10 = 1 for RDA/WRA.
REQ-021 A10 SHALL be 0 for PRE and 1 for PREA.
REQ-022 LMR SHALL drive ddr_addr = cmd_mode with ddr_ba = 0; EMR SHALL drive ddr_addr = cmd_mode with ddr_ba = 1.
REQ-023 ddr_cke SHALL be {RANK_N{cke_en}} except from the SREF_EN/PDN_EN issue cycle until the exit issue cycle, where it SHALL be all 0.
REQ-024 SREF_EX/PDN_EX SHALL drive cke high with a deselect.
REQ-025 Rank index >= RANK_N SHALL deselect all ranks, issue nothing, and set protocol_err.

Reset
REQ-026 While rst_n = 0 at a clk edge: state IDLE, ddr_cke 0, ddr_cs_n all 1, ras/cas/we 1, ddr_addr 0, ddr_ba 0, counter 0, bank_open 0, protocol_err 0.
REQ-027 cmd_ready SHALL be 0 during reset and SHALL go to 1 the first cycle after release.
REQ-028 Reset mid-GAP or mid-SREF SHALL abort immediately to the reset values above.

Configuration
REQ-029 With macro DDR_BANK_TRACK_EN defined: ACT SHALL set bank_open[rank*2^BANK_W+bank].
REQ-030 With DDR_BANK_TRACK_EN defined: PRE, RDA, and WRA SHALL clear that bit; PREA SHALL clear all bits.
REQ-031 With DDR_BANK_TRACK_EN defined: protocol_err SHALL set on ACT to an open bank, on RD/WR/RDA/WRA to a closed bank, and on REF, LMR, EMR, or SREF_EN with any bit set; the command is still issued.
REQ-032 Without DDR_BANK_TRACK_EN: bank_open SHALL be constant 0, and protocol_err SHALL set only per REQ-010 and REQ-025.

Verification
REQ-033 Defaults, cke_en=1, ACT row 0x1A5 rank 1 bank 2 -> next cycle cs_n=2'b01, RAS/CAS/WE=011, addr=0x1A5, ba=2; cmd_ready low 2 cycles.
REQ-034 RDA col 0x0F3 rank 0 bank 2 after ACT -> cs_n=2'b10, addr=0x4F3, ba=2; bank_open bit 2 clears.
REQ-035 SREF_EN, then RD held valid 10 cycles -> cke=00, cmd_ready 0; SREF_EX -> cke=11, cmd_ready returns after 200 NOP cycles.
REQ-036 DDR_BANK_TRACK_EN defined, RD to closed bank -> RD still issued, protocol_err=1 until reset.
REQ-037 cmd_op=15 and, separately, RANK_N=3 with rank 3 -> no cs_n low, protocol_err=1.
REQ-038 rst_n=0 during GAP of a WR -> next cycle all outputs at reset values, bank_open=0.
